fadc_result_avg: RTL and testbench

Digital post-processing stage directly downstream of the flash-ADC control state machine in the `fadc_ctrl` block. It takes each finished conversion as a 4-bit comparator thermometer code with a one-cycle strobe and converts it to a 0..4 value. It sums a fixed number of conversions into one result word. It buffers result words in a small FIFO that the pad or scan side drains with a read-enable handshake.

---
 rtl/fadc_result_avg.sv | 123 ++++++++++++
 tb/tb_fadc_result_avg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fadc_result_avg.sv
// Flash-ADC result averager: turns thermometer codes into 0..4 values, sums
// 2^LOG2_AVG of them into one word and queues the words in a small FIFO.
module fadc_result_avg #(
  parameter int LOG2_AVG   = 3,
  parameter int LOG2_DEPTH = 2,
  localparam int W         = LOG2_AVG + 3
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  CONV_VALID,
  input  logic [3:0]            CONV_CODE,
  input  logic                  RD_EN,
  output logic [W-1:0]          RD_DATA,
  output logic                  RD_VALID,
  output logic                  FIFO_EMPTY,
  output logic                  FIFO_FULL,
  output logic [LOG2_DEPTH:0]   FIFO_LEVEL,
  output logic                  OVF,
  output logic                  BUBBLE_ERR,
  output logic                  ACC_BUSY
);
  localparam int NAVG  = 1 << LOG2_AVG;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CW    = LOG2_AVG + 1;
  localparam int LW    = LOG2_DEPTH + 1;

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  state_t                state;
  logic [W-1:0]          acc;
  logic [CW-1:0]         cnt;
  logic [2:0]            code_val;
  logic                  code_legal;
  logic                  wr_req;
  logic [W-1:0]          wr_word;
  logic                  push, pop;
  logic [LW-1:0]         level_nxt;
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]          mem [DEPTH];

  always_comb begin
    code_val = 3'(CONV_CODE[0]) + 3'(CONV_CODE[1]) + 3'(CONV_CODE[2]) + 3'(CONV_CODE[3]);
    case (CONV_CODE)
      4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111: code_legal = 1'b1;
      default:                                     code_legal = 1'b0;
    endcase
  end

  // In ST_IDLE acc is zero, so acc + code is the correct word for AVG=1 too.
  always_comb begin
    wr_word = acc + W'(code_val);
    wr_req  = 1'b0;
    if (CONV_VALID) begin
      if (LOG2_AVG == 0)
        wr_req = 1'b1;
      else if (state == ST_ACC && cnt == CW'(NAVG - 1))
        wr_req = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST || CLR) begin
      state      <= ST_IDLE;
      acc        <= '0;
      cnt        <= '0;
      ACC_BUSY   <= 1'b0;
      BUBBLE_ERR <= 1'b0;
    end else if (CONV_VALID) begin
      if (!code_legal) BUBBLE_ERR <= 1'b1;
      if (wr_req) begin
        state    <= ST_IDLE;
        acc      <= '0;
        cnt      <= '0;
        ACC_BUSY <= 1'b0;
      end else begin
        state    <= ST_ACC;
        acc      <= wr_word;
        cnt      <= cnt + CW'(1);
        ACC_BUSY <= 1'b1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  always_comb begin
    pop       = RD_EN && !FIFO_EMPTY;
    push      = wr_req && (!FIFO_FULL || pop);
    level_nxt = FIFO_LEVEL;
    if (push && !pop)
      level_nxt = FIFO_LEVEL + LW'(1);
    else if (pop && !push)
      level_nxt = FIFO_LEVEL - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (RST || CLR) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
      FIFO_EMPTY <= 1'b1;
      FIFO_FULL  <= 1'b0;
      RD_DATA    <= '0;
      RD_VALID   <= 1'b0;
      OVF        <= 1'b0;
    end else begin
      RD_VALID <= pop;
      if (pop) begin
        RD_DATA <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + LOG2_DEPTH'(1);
      end
      if (push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      if (wr_req && !push) OVF <= 1'b1;
      FIFO_LEVEL <= level_nxt;
      FIFO_EMPTY <= (level_nxt == '0);
      FIFO_FULL  <= (level_nxt == LW'(DEPTH));
    end
  end
endmodule

// File: tb/tb_fadc_result_avg.sv
// Bench for fadc_result_avg: directed plan steps plus randomized traffic,
// compared each cycle against a queue-based model of the averager.
module tb_fadc_result_avg;
  localparam int LA = 3;
  localparam int LD = 2;
  localparam int W  = LA + 3;
  localparam int N  = 1 << LA;
  localparam int D  = 1 << LD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, clr = 1'b0, cv = 1'b0, rd = 1'b0;
  logic [3:0]   code = '0;
  logic [W-1:0] rd_data;
  logic         rd_valid, f_empty, f_full, ovf, bubble, busy;
  logic [LD:0]  f_level;

  logic         clr0 = 1'b0, cv0 = 1'b0, rd0 = 1'b0;
  logic [3:0]   code0 = '0;
  logic [2:0]   rd_data0;
  logic         rd_valid0, f_empty0, f_full0, ovf0, bubble0, busy0;
  logic [LD:0]  f_level0;

  fadc_result_avg #(.LOG2_AVG(LA), .LOG2_DEPTH(LD)) dut (
    .clk(clk), .RST(rst), .CLR(clr), .CONV_VALID(cv), .CONV_CODE(code), .RD_EN(rd),
    .RD_DATA(rd_data), .RD_VALID(rd_valid), .FIFO_EMPTY(f_empty), .FIFO_FULL(f_full),
    .FIFO_LEVEL(f_level), .OVF(ovf), .BUBBLE_ERR(bubble), .ACC_BUSY(busy));

  fadc_result_avg #(.LOG2_AVG(0), .LOG2_DEPTH(LD)) dut0 (
    .clk(clk), .RST(rst), .CLR(clr0), .CONV_VALID(cv0), .CONV_CODE(code0), .RD_EN(rd0),
    .RD_DATA(rd_data0), .RD_VALID(rd_valid0), .FIFO_EMPTY(f_empty0), .FIFO_FULL(f_full0),
    .FIFO_LEVEL(f_level0), .OVF(ovf0), .BUBBLE_ERR(bubble0), .ACC_BUSY(busy0));

  int checks = 0;
  int errors = 0;

  // reference state: stored words, pending sample values, sticky flags
  int fifo_q[$];
  int samp_q[$];
  int m_rdata = 0, m_rvalid = 0, m_ovf = 0, m_bub = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit v, input logic [3:0] cd, input bit re);
    bit full_b, pop;
    int s;
    rst = r; clr = c; cv = v; code = cd; rd = re;
    @(posedge clk);
    if (r || c) begin
      fifo_q.delete(); samp_q.delete();
      m_rdata = 0; m_rvalid = 0; m_ovf = 0; m_bub = 0;
    end else begin
      full_b   = (fifo_q.size() == D);
      pop      = re && (fifo_q.size() > 0);
      m_rvalid = pop;
      if (pop) m_rdata = fifo_q.pop_front();
      if (v) begin
        samp_q.push_back($countones(cd));
        if (!(cd inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111})) m_bub = 1;
        if (samp_q.size() == N) begin
          s = samp_q.sum();
          samp_q.delete();
          if (full_b && !pop) m_ovf = 1;
          else fifo_q.push_back(s);
        end
      end
    end
    #1;
    rst = 1'b0; clr = 1'b0; cv = 1'b0; rd = 1'b0;
    chk("rd_valid", rd_valid, m_rvalid);
    chk("rd_data", rd_data, m_rdata);
    chk("level", f_level, fifo_q.size());
    chk("empty", f_empty, fifo_q.size() == 0);
    chk("full", f_full, fifo_q.size() == D);
    chk("ovf", ovf, m_ovf);
    chk("bubble", bubble, m_bub);
    chk("busy", busy, samp_q.size() > 0);
  endtask

  task automatic word(input logic [3:0] cd);
    for (int i = 0; i < N; i++) step(0, 0, 1, cd, 0);
  endtask

  task automatic rand_word();
    for (int i = 0; i < N; i++) step(0, 0, 1, 4'($urandom_range(0, 15)), 0);
  endtask

  logic [3:0] mixed [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0101, 4'b0000, 4'b0000};
  logic [3:0] legal [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

  initial begin
    // reset state
    step(1, 0, 0, 4'h0, 0);
    step(1, 0, 0, 4'h0, 0);
    chk("rst_empty", f_empty, 1);
    chk("rst_level0", f_level0, 0);

    // averaging by one: every pulse is a word
    cv0 = 1; code0 = 4'b0111; @(posedge clk); #1; cv0 = 0;
    chk("avg1_level", f_level0, 1);
    chk("avg1_busy", busy0, 0);
    rd0 = 1; @(posedge clk); #1; rd0 = 0;
    chk("avg1_data", rd_data0, 3);
    chk("avg1_valid", rd_valid0, 1);
    rd0 = 1; @(posedge clk); #1; rd0 = 0;
    chk("avg1_empty_rd_valid", rd_valid0, 0);
    chk("avg1_empty_rd_data", rd_data0, 3);

    // basic sum
    word(4'b1111);
    chk("basic_level", f_level, 1);
    step(0, 0, 0, 4'h0, 1);
    chk("basic_sum", rd_data, 32);
    chk("basic_empty", f_empty, 1);
    step(0, 0, 0, 4'h0, 0);

    // mixed codes with a bubble
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, mixed[i], 0);
      if (i == 4) chk("bubble_pre", bubble, 0);
      if (i == 5) chk("bubble_rise", bubble, 1);
    end
    step(0, 0, 0, 4'h0, 1);
    chk("mixed_sum", rd_data, 12);

    // overflow
    step(1, 0, 0, 4'h0, 0);
    for (int w = 0; w < 5; w++) begin
      rand_word();
      if (w == 3) chk("ovf_full4", f_full, 1);
    end
    chk("ovf_set", ovf, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 1);
    step(0, 0, 0, 4'h0, 0);

    // full FIFO with write and pop on the same edge
    step(1, 0, 0, 4'h0, 0);
    for (int w = 0; w < 4; w++) rand_word();
    for (int i = 0; i < N - 1; i++) step(0, 0, 1, 4'b0011, 0);
    step(0, 0, 1, 4'b0111, 1);
    chk("wp_level", f_level, 4);
    chk("wp_ovf", ovf, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 1);
    chk("wp_last", rd_data, 17);

    // clear mid-accumulation
    for (int i = 0; i < 5; i++) step(0, 0, 1, 4'b1111, 0);
    step(0, 1, 1, 4'b1111, 1);
    chk("clr_busy", busy, 0);
    chk("clr_level", f_level, 0);
    word(4'b0011);
    chk("clr_one_word", f_level, 1);
    step(0, 0, 0, 4'h0, 1);
    chk("clr_sum", rd_data, 16);
    step(0, 0, 0, 4'h0, 1);
    chk("empty_rd_valid", rd_valid, 0);
    chk("empty_rd_data", rd_data, 16);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] cd;
      cd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 4)];
      step(0, $urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, cd, $urandom_range(0, 9) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
